// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame arbiter and related page blocks.
package lcd_pkg;

  localparam int LCD_CHARS = 32;
  localparam int FRAME_W   = 256;
  localparam int NREQ      = 2;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Round-robin winner: a lone requester wins, a tie goes to whoever did not own last.
  function automatic logic pick(input logic [NREQ-1:0] req, input logic last_owner);
    if (req == 2'b11) return ~last_owner;
    return req[1];
  endfunction

endpackage

// File: rtl/lcd_dwell_timer.sv
// Load/decrement dwell counter with a zero flag; parked at zero until reloaded.
module lcd_dwell_timer #(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_frame_arbiter.sv
// Round-robin owner of the 32-char LCD text buffer with a fixed dwell per grant.
// Optional LCD_OWNER_TAG_EN: last character shows the owner index ('-' when idle).
module lcd_frame_arbiter
  import lcd_pkg::*;
#(
  parameter int                 DWELL_CYCLES = 100_000_000,
  parameter logic [FRAME_W-1:0] IDLE_FRAME   = {"        IDLE            ", {8{ASCII_SPACE}}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [FRAME_W-1:0] frame0,
  input  logic [FRAME_W-1:0] frame1,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               owner,
  output logic [FRAME_W-1:0] chars_out
);

`ifdef LCD_OWNER_TAG_EN
  localparam logic [FRAME_W-1:0] RESET_FRAME = {IDLE_FRAME[FRAME_W-1:8], ASCII_DASH};
`else
  localparam logic [FRAME_W-1:0] RESET_FRAME = IDLE_FRAME;
`endif

  state_t             state, state_n;
  logic [NREQ-1:0]    grant_n, done_n;
  logic               busy_n, owner_n;
  logic               last_owner, last_owner_n;
  logic [FRAME_W-1:0] frame_n;
  logic               win, arb, load, dwell_zero;

  lcd_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .en   (state == SHOW),
    .zero (dwell_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      chars_out  <= RESET_FRAME;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      done       <= done_n;
      busy       <= busy_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      chars_out  <= frame_n;
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = '0;
    done_n       = '0;
    busy_n       = busy;
    owner_n      = owner;
    last_owner_n = last_owner;
    frame_n      = chars_out;
    arb          = 1'b0;
    win          = pick(req, last_owner);

    case (state)
      IDLE: begin
        arb = (req != '0);
      end
      SHOW: begin
        // Requests are ignored until the dwell expires; no pre-emption.
        if (dwell_zero) begin
          done_n[owner] = 1'b1;
          if (req != '0) begin
            arb = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            frame_n = IDLE_FRAME;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (arb) begin
      grant_n[win] = 1'b1;
      frame_n      = win ? frame1 : frame0;
      owner_n      = win;
      last_owner_n = win;
      busy_n       = 1'b1;
      state_n      = SHOW;
    end

`ifdef LCD_OWNER_TAG_EN
    frame_n[7:0] = (state_n == SHOW) ? (ASCII_ZERO + {7'd0, owner_n}) : ASCII_DASH;
`endif
  end

  assign load = arb;

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Scoreboard bench for lcd_frame_arbiter with DWELL_CYCLES=10; honours LCD_OWNER_TAG_EN.
module tb_lcd_frame_arbiter;

  localparam int DW = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [255:0] frame0 = '0;
  logic [255:0] frame1 = '0;
  logic [1:0]   grant, done;
  logic         busy, owner;
  logic [255:0] chars_out;

  lcd_frame_arbiter #(.DWELL_CYCLES(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .frame0   (frame0),
    .frame1   (frame1),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .owner    (owner),
    .chars_out(chars_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   grant;
    logic [1:0]   done;
    logic         busy;
    logic         owner;
    logic [255:0] chars;
  } ev_t;

  typedef struct {
    ev_t e;
    int  gap;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_ev_cyc = 0;

  logic [255:0] IDLE_F, F0, F0B, F1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] disp(input logic [255:0] f, input logic show, input logic own);
    logic [255:0] r;
    r = f;
`ifdef LCD_OWNER_TAG_EN
    r[7:0] = show ? (8'h30 + {7'd0, own}) : 8'h2D;
`else
    if (show && own) r = f;
`endif
    return r;
  endfunction

  function automatic ev_t mk(input logic [1:0] g, input logic [1:0] d, input logic b,
                             input logic o, input logic [255:0] c);
    ev_t e;
    e.grant = g; e.done = d; e.busy = b; e.owner = o; e.chars = c;
    return e;
  endfunction

  task automatic expect_ev(input ev_t e, input int gap);
    exp_t x;
    x.e = e; x.gap = gap;
    q.push_back(x);
  endtask

  task automatic check(input string name, input logic [263:0] act, input logic [263:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req_v);
    end
  endtask

  // Monitor: every grant/done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (grant != 2'b00 || done != 2'b00)) begin
      ev_t act;
      act = mk(grant, done, busy, owner, chars_out);
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got g=%b d=%b busy=%b at cycle %0d, expected none",
                 grant, done, busy, cyc);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (act !== x.e || (x.gap >= 0 && (cyc - last_ev_cyc) != x.gap)) begin
          fails++;
          $display("FAIL event: got g=%b d=%b b=%b o=%b gap=%0d chars=%h, expected g=%b d=%b b=%b o=%b gap=%0d chars=%h",
                   act.grant, act.done, act.busy, act.owner, cyc - last_ev_cyc, act.chars,
                   x.e.grant, x.e.done, x.e.busy, x.e.owner, x.gap, x.e.chars);
        end
      end
      last_ev_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    req = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {2'b00, 2'b00, busy, owner, chars_out, 2'b00},
          {grant, done, 1'b0, 1'b0, disp(IDLE_F, 1'b0, 1'b0), 2'b00});
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    IDLE_F = {"        IDLE            ", "        "};
    F0     = "Hello World!!!!! Value: 0005    ";
    F0B    = "CHANGED FRAME 0 SHOULD NOT SHOW!";
    F1     = "Requester one frame text ......Z";

    // Single grant, dwell, drop to idle
    do_reset();
    frame0 = F0; req = 2'b01;
    expect_ev(mk(2'b01, 2'b00, 1'b1, 1'b0, disp(F0, 1'b1, 1'b0)), -1);
    expect_ev(mk(2'b00, 2'b01, 1'b0, 1'b0, disp(IDLE_F, 1'b0, 1'b0)), DW);
    @(negedge clk);
    req = 2'b00;
    repeat (5) @(negedge clk);
    check("busy_mid_dwell", {263'd0, busy}, {263'd0, 1'b1});
    repeat (7) @(negedge clk);
    check("idle_after_dwell", {7'd0, busy, chars_out}, {7'd0, 1'b0, disp(IDLE_F, 1'b0, 1'b0)});

    // Round-robin with both requesting
    do_reset();
    frame0 = F0; frame1 = F1; req = 2'b11;
    expect_ev(mk(2'b01, 2'b00, 1'b1, 1'b0, disp(F0, 1'b1, 1'b0)), -1);
    expect_ev(mk(2'b10, 2'b01, 1'b1, 1'b1, disp(F1, 1'b1, 1'b1)), DW);
    expect_ev(mk(2'b01, 2'b10, 1'b1, 1'b0, disp(F0, 1'b1, 1'b0)), DW);
    expect_ev(mk(2'b00, 2'b01, 1'b0, 1'b0, disp(IDLE_F, 1'b0, 1'b0)), DW);
    repeat (21) @(negedge clk);
    req = 2'b00;
    repeat (12) @(negedge clk);

    // No pre-emption; frozen display; owner tag on requester 1
    do_reset();
    frame0 = F0; frame1 = F1; req = 2'b01;
    expect_ev(mk(2'b01, 2'b00, 1'b1, 1'b0, disp(F0, 1'b1, 1'b0)), -1);
    expect_ev(mk(2'b10, 2'b01, 1'b1, 1'b1, disp(F1, 1'b1, 1'b1)), DW);
    expect_ev(mk(2'b00, 2'b10, 1'b0, 1'b1, disp(IDLE_F, 1'b0, 1'b0)), DW);
    repeat (3) @(negedge clk);
    req = 2'b11; frame0 = F0B;
    repeat (5) @(negedge clk);
    check("frozen_display", {8'd0, chars_out}, {8'd0, disp(F0, 1'b1, 1'b0)});
    repeat (3) @(negedge clk);
    req = 2'b00;
    @(negedge clk);
`ifdef LCD_OWNER_TAG_EN
    check("tag_owner1", {256'd0, chars_out[7:0]}, {256'd0, 8'h31});
`else
    check("tag_owner1", {256'd0, chars_out[7:0]}, {256'd0, F1[7:0]});
`endif
    repeat (10) @(negedge clk);
`ifdef LCD_OWNER_TAG_EN
    check("tag_idle", {256'd0, chars_out[7:0]}, {256'd0, 8'h2D});
`else
    check("tag_idle", {256'd0, chars_out[7:0]}, {256'd0, 8'h20});
`endif
    check("owner_held", {263'd0, owner}, {263'd0, 1'b1});

    // Lone requester re-granted back-to-back
    do_reset();
    frame1 = F1; req = 2'b10;
    expect_ev(mk(2'b10, 2'b00, 1'b1, 1'b1, disp(F1, 1'b1, 1'b1)), -1);
    expect_ev(mk(2'b10, 2'b10, 1'b1, 1'b1, disp(F1, 1'b1, 1'b1)), DW);
    expect_ev(mk(2'b00, 2'b10, 1'b0, 1'b1, disp(IDLE_F, 1'b0, 1'b0)), DW);
    repeat (11) @(negedge clk);
    req = 2'b00;
    repeat (12) @(negedge clk);

    // Mid-dwell reset: no done pulse afterwards
    do_reset();
    frame0 = F0; req = 2'b01;
    expect_ev(mk(2'b01, 2'b00, 1'b1, 1'b0, disp(F0, 1'b1, 1'b0)), -1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; req = 2'b00;
    @(negedge clk);
    check("mid_reset", {7'd0, busy, chars_out}, {7'd0, 1'b0, disp(IDLE_F, 1'b0, 1'b0)});
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    check("queue_drained", {232'd0, 32'(q.size())}, 264'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
